// File: rtl/alu_arb_pkg.sv
// Shared types and ALU opcode constants for the ALU arbiter slice.
// Imported by the arbiter top and its round-robin picker.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True for the opcodes the arbiter's users are known to issue; codes are not filtered.
    function automatic logic is_base_op(input logic [3:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB) || (ctrl == ALU_XOR) || (ctrl == ALU_SLL);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels between NREQ requesters and the ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_arb_if #(
    parameter int NREQ = 2,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][XLEN-1:0] req_srca;
    logic [NREQ-1:0][XLEN-1:0] req_srcb;
    logic [NREQ-1:0][3:0]      req_ctrl;
    logic [NREQ-1:0]           rsp_valid;
    logic [NREQ-1:0]           rsp_ready;
    logic [XLEN-1:0]           rsp_result;
    logic                      rsp_zero;

    modport master (
        output req_valid, req_srca, req_srcb, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_srca, req_srcb, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requester above last wins,
// otherwise wrap to the lowest requester overall.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    logic [NREQ-1:0] mask_hi;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] src;
    logic [IW-1:0]   idx_acc [NREQ+1];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign mask_hi[gi] = (IW'(gi) > last);
        end
    endgenerate

    assign req_hi = req & mask_hi;
    assign src    = (|req_hi) ? req_hi : req;
    // Isolate the lowest set bit of the chosen search vector.
    assign gnt    = src & (~src + NREQ'(1));
    assign any    = |req;

    assign idx_acc[0] = '0;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_idx
            assign idx_acc[gi+1] = idx_acc[gi] | (gnt[gi] ? IW'(gi) : '0);
        end
    endgenerate
    assign idx = idx_acc[NREQ];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_arb_if.slave        bus,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [3:0]      ALUControl,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            Zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0] grant_cnt
`endif
);
    localparam int IW = idx_width(NREQ);

    arb_state_t state_reg, state_next;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic [IW-1:0]   last_grant_reg;
    logic [NREQ-1:0] grant_oh_reg;
    logic [XLEN-1:0] srca_reg, srcb_reg, result_reg;
    logic [3:0]      ctrl_reg;
    logic            zero_reg;
    logic            accept, consume;

    logic [XLEN-1:0] sel_a [NREQ+1];
    logic [XLEN-1:0] sel_b [NREQ+1];
    logic [3:0]      sel_c [NREQ+1];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (bus.req_valid),
        .last (last_grant_reg),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // One-hot AND-OR operand mux driven by the picker's grant.
    assign sel_a[0] = '0;
    assign sel_b[0] = '0;
    assign sel_c[0] = '0;
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_opmux
            assign sel_a[gi+1] = sel_a[gi] | (pick_gnt[gi] ? bus.req_srca[gi] : '0);
            assign sel_b[gi+1] = sel_b[gi] | (pick_gnt[gi] ? bus.req_srcb[gi] : '0);
            assign sel_c[gi+1] = sel_c[gi] | (pick_gnt[gi] ? bus.req_ctrl[gi] : '0);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (consume) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        accept        = 1'b0;
        consume       = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.req_ready = pick_gnt;
                accept        = pick_any;
            end
            RESP: begin
                bus.rsp_valid = grant_oh_reg;
                // Only the granted requester's rsp_ready can retire the response.
                consume       = |(bus.rsp_ready & grant_oh_reg);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srca_reg       <= '0;
            srcb_reg       <= '0;
            ctrl_reg       <= ALU_ADD;
            grant_oh_reg   <= '0;
            last_grant_reg <= IW'(NREQ - 1);
            result_reg     <= '0;
            zero_reg       <= 1'b0;
        end else begin
            if (accept) begin
                srca_reg       <= sel_a[NREQ];
                srcb_reg       <= sel_b[NREQ];
                ctrl_reg       <= sel_c[NREQ];
                grant_oh_reg   <= pick_gnt;
                last_grant_reg <= pick_idx;
            end
            if (state_reg == EXEC) begin
                result_reg <= ALUResult;
                zero_reg   <= Zero;
            end
        end
    end

    assign SrcA           = srca_reg;
    assign SrcB           = srcb_reg;
    assign ALUControl     = ctrl_reg;
    assign bus.rsp_result = result_reg;
    assign bus.rsp_zero   = zero_reg;

`ifdef ALU_ARB_STATS_EN
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (accept && pick_gnt[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign grant_cnt[gi] = cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (NREQ=2 and NREQ=4 instances).
// Grant-counter checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    alu_arb_if #(.NREQ(2), .XLEN(32)) bus2 ();
    alu_arb_if #(.NREQ(4), .XLEN(32)) bus4 ();

    logic [31:0] srca2, srcb2, res2, srca4, srcb4, res4;
    logic [3:0]  ctrl2, ctrl4;
    logic        zero2, zero4;

`ifdef ALU_ARB_STATS_EN
    logic [1:0][15:0] gcnt2;
    logic [3:0][15:0] gcnt4;
`endif

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_SLL: return a << b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    assign res2  = alu_f(srca2, srcb2, ctrl2);
    assign zero2 = (res2 == 32'h0);
    assign res4  = alu_f(srca4, srcb4, ctrl4);
    assign zero4 = (res4 == 32'h0);

    alu_arbiter #(.NREQ(2), .XLEN(32)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus2.slave),
        .SrcA       (srca2),
        .SrcB       (srcb2),
        .ALUControl (ctrl2),
        .ALUResult  (res2),
        .Zero       (zero2)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt  (gcnt2)
`endif
    );

    alu_arbiter #(.NREQ(4), .XLEN(32)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus4.slave),
        .SrcA       (srca4),
        .SrcB       (srcb4),
        .ALUControl (ctrl4),
        .ALUResult  (res4),
        .Zero       (zero4)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt  (gcnt4)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", bus2.req_ready); end
        checks++; if (bus2.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", bus2.rsp_valid); end
        checks++; if (bus2.rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", bus2.rsp_result); end
        checks++; if (bus2.rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_rsp_zero got %b want 0", bus2.rsp_zero); end
        checks++; if ({srca2, srcb2, ctrl2} !== 68'h0) begin errors++; $display("FAIL reset_alu_drive got %h/%h/%h want 0/0/0", srca2, srcb2, ctrl2); end
        checks++; if (bus4.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid4 got %b want 0000", bus4.rsp_valid); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL idle_no_req_ready got %b want 00", bus2.req_ready); end
        $display("reset: done");
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bus2.req_srca[0] = 32'd10; bus2.req_srcb[0] = 32'd20; bus2.req_ctrl[0] = ALU_ADD;
        bus2.req_valid = 2'b01;
        @(negedge clk);
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b want 01", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(negedge clk);
        checks++; if ({srca2, srcb2, ctrl2} !== {32'd10, 32'd20, ALU_ADD}) begin errors++; $display("FAIL single_alu_drive got %0d/%0d/%h want 10/20/0", srca2, srcb2, ctrl2); end
        checks++; if ({bus2.req_ready, bus2.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL single_exec_quiet got %b/%b want 00/00", bus2.req_ready, bus2.rsp_valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus2.rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b want 01", bus2.rsp_valid); end
        checks++; if (bus2.rsp_result !== 32'd30) begin errors++; $display("FAIL single_rsp_result got %0d want 30", bus2.rsp_result); end
        checks++; if (bus2.rsp_zero !== 1'b0) begin errors++; $display("FAIL single_rsp_zero got %b want 0", bus2.rsp_zero); end
        bus2.rsp_ready = 2'b01;
        @(posedge clk); #1;
        bus2.rsp_ready = 2'b00;
        @(negedge clk);
        checks++; if (bus2.rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_retired got %b want 00", bus2.rsp_valid); end
        $display("single: req0 10 ADD 20 -> %0d", bus2.rsp_result);
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        bus2.req_srca[1] = 32'd100; bus2.req_srcb[1] = 32'd100; bus2.req_ctrl[1] = ALU_SUB;
        bus2.req_valid = 2'b10;
        @(negedge clk);
        checks++; if (bus2.req_ready !== 2'b10) begin errors++; $display("FAIL hold_req_ready got %b want 10", bus2.req_ready); end
        @(posedge clk); #1;
        // req0 now contends and the non-granted rsp_ready is asserted; both must be ignored
        bus2.req_srca[0] = 32'd1; bus2.req_srcb[0] = 32'd2; bus2.req_ctrl[0] = ALU_ADD;
        bus2.req_valid = 2'b01;
        bus2.rsp_ready = 2'b01;
        @(negedge clk);
        checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL hold_exec_ready got %b want 00", bus2.req_ready); end
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus2.rsp_valid !== 2'b10) begin errors++; $display("FAIL hold_rsp_valid[%0d] got %b want 10", i, bus2.rsp_valid); end
            checks++; if ({bus2.rsp_result, bus2.rsp_zero} !== {32'h0, 1'b1}) begin errors++; $display("FAIL hold_rsp_data[%0d] got %h/%b want 0/1", i, bus2.rsp_result, bus2.rsp_zero); end
            checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL hold_no_grant[%0d] got %b want 00", i, bus2.req_ready); end
            @(posedge clk);
        end
        #1;
        bus2.req_valid = 2'b00;
        bus2.rsp_ready = 2'b10;
        @(posedge clk); #1;
        bus2.rsp_ready = 2'b00;
        @(negedge clk);
        checks++; if ({bus2.req_ready, bus2.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL hold_released got %b/%b want 00/00", bus2.req_ready, bus2.rsp_valid); end
        $display("hold: req1 100 SUB 100 held 5 cycles -> %0d zero", bus2.rsp_result);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_oh;
        logic [31:0] exp_res;
        bus2.req_srca[0] = 32'hF0F0F0F0; bus2.req_srcb[0] = 32'hFFFF0000; bus2.req_ctrl[0] = ALU_XOR;
        bus2.req_srca[1] = 32'h1;        bus2.req_srcb[1] = 32'h4;        bus2.req_ctrl[1] = ALU_SLL;
        bus2.req_valid = 2'b11;
        bus2.rsp_ready = 2'b11;
        for (int op = 0; op < 4; op++) begin
            exp_oh  = (op % 2 == 0) ? 2'b01 : 2'b10;
            exp_res = (op % 2 == 0) ? 32'h0F0FF0F0 : 32'h00000010;
            @(negedge clk);
            checks++; if (bus2.req_ready !== exp_oh) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", op, bus2.req_ready, exp_oh); end
            @(posedge clk);
            @(negedge clk);
            checks++; if ({bus2.req_ready, bus2.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL rr_exec[%0d] got %b/%b want 00/00", op, bus2.req_ready, bus2.rsp_valid); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus2.rsp_valid !== exp_oh) begin errors++; $display("FAIL rr_rsp_valid[%0d] got %b want %b", op, bus2.rsp_valid, exp_oh); end
            checks++; if (bus2.rsp_result !== exp_res) begin errors++; $display("FAIL rr_rsp_result[%0d] got %h want %h", op, bus2.rsp_result, exp_res); end
            $display("rr: op %0d grant %b result %h", op, bus2.rsp_valid, bus2.rsp_result);
            @(posedge clk);
        end
        #1;
        bus2.req_valid = 2'b00;
        bus2.rsp_ready = 2'b00;
        @(negedge clk);
        checks++; if ({bus2.req_ready, bus2.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL rr_drained got %b/%b want 00/00", bus2.req_ready, bus2.rsp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus2.req_srca[0] = 32'd5; bus2.req_srcb[0] = 32'd6; bus2.req_ctrl[0] = ALU_ADD;
        bus2.req_srca[1] = 32'd9; bus2.req_srcb[1] = 32'd9; bus2.req_ctrl[1] = ALU_ADD;
        bus2.req_valid = 2'b01;
        @(negedge clk);
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL midrst_req_ready got %b want 01", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        #2 reset = 1'b1;
        #1;
        checks++; if ({bus2.req_ready, bus2.rsp_valid} !== 4'b0000) begin errors++; $display("FAIL midrst_async got %b/%b want 00/00", bus2.req_ready, bus2.rsp_valid); end
        checks++; if (srca2 !== 32'h0) begin errors++; $display("FAIL midrst_srca got %h want 0", srca2); end
        @(posedge clk); #1;
        checks++; if (bus2.rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_discard got %b want 00", bus2.rsp_valid); end
        @(negedge clk);
        reset = 1'b0;
        bus2.req_valid = 2'b11;
        #1;
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant got %b want 01", bus2.req_ready); end
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus2.rsp_valid, bus2.rsp_result} !== {2'b01, 32'd11}) begin errors++; $display("FAIL midrst_rsp got %b/%0d want 01/11", bus2.rsp_valid, bus2.rsp_result); end
        $display("reset_mid: after reset grant %b result %0d", bus2.rsp_valid, bus2.rsp_result);
        bus2.rsp_ready = 2'b01;
        @(posedge clk); #1;
        bus2.rsp_ready = 2'b00;
    endtask

    task automatic test_nreq4();
        bus4.rsp_ready = 4'b1111;
        bus4.req_srca[1] = 32'd7; bus4.req_srcb[1] = 32'd8; bus4.req_ctrl[1] = ALU_ADD;
        bus4.req_srca[3] = 32'd3; bus4.req_srcb[3] = 32'd2; bus4.req_ctrl[3] = ALU_SUB;
        bus4.req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (bus4.req_ready !== 4'b0010) begin errors++; $display("FAIL n4_first got %b want 0010", bus4.req_ready); end
        @(posedge clk); #1;
        bus4.req_valid = 4'b1010;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus4.rsp_valid, bus4.rsp_result} !== {4'b0010, 32'd15}) begin errors++; $display("FAIL n4_rsp1 got %b/%0d want 0010/15", bus4.rsp_valid, bus4.rsp_result); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus4.req_ready !== 4'b1000) begin errors++; $display("FAIL n4_grant3 got %b want 1000", bus4.req_ready); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus4.rsp_valid, bus4.rsp_result} !== {4'b1000, 32'd1}) begin errors++; $display("FAIL n4_rsp3 got %b/%0d want 1000/1", bus4.rsp_valid, bus4.rsp_result); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus4.req_ready !== 4'b0010) begin errors++; $display("FAIL n4_grant1 got %b want 0010", bus4.req_ready); end
        @(posedge clk); #1;
        bus4.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus4.rsp_valid, bus4.rsp_result} !== {4'b0010, 32'd15}) begin errors++; $display("FAIL n4_rsp1b got %b/%0d want 0010/15", bus4.rsp_valid, bus4.rsp_result); end
        $display("nreq4: grants 1,3,1 observed");
        @(posedge clk); #1;
        bus4.rsp_ready = 4'b0000;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic do_op2(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus2.req_srca[r] = a; bus2.req_srcb[r] = b; bus2.req_ctrl[r] = c;
        bus2.req_valid[r] = 1'b1;
        @(posedge clk); #1;
        bus2.req_valid = 2'b00;
        @(posedge clk); #1;
        bus2.rsp_ready = 2'b11;
        @(posedge clk); #1;
        bus2.rsp_ready = 2'b00;
    endtask

    task automatic test_stats();
        do_op2(0, 32'd1, 32'd1, ALU_ADD);
        do_op2(0, 32'd2, 32'd2, ALU_ADD);
        @(negedge clk);
        checks++; if (gcnt2[0] !== 16'd3) begin errors++; $display("FAIL stats_cnt0 got %0d want 3", gcnt2[0]); end
        checks++; if (gcnt2[1] !== 16'd0) begin errors++; $display("FAIL stats_cnt1 got %0d want 0", gcnt2[1]); end
        checks++; if ({gcnt4[3], gcnt4[1], gcnt4[0]} !== {16'd1, 16'd2, 16'd0}) begin errors++; $display("FAIL stats_cnt4 got %0d/%0d/%0d want 1/2/0", gcnt4[3], gcnt4[1], gcnt4[0]); end
        $display("stats: req0 grants %0d", gcnt2[0]);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus2.req_valid = '0; bus2.rsp_ready = '0;
        bus2.req_srca = '0; bus2.req_srcb = '0; bus2.req_ctrl = '0;
        bus4.req_valid = '0; bus4.rsp_ready = '0;
        bus4.req_srca = '0; bus4.req_srcb = '0; bus4.req_ctrl = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_nreq4();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
